// File: rtl/branch_resolve_unit_if.sv
// Bundle of the decoded B-type input beat and the registered branch result.
// master drives the beat and out_ready; slave is the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [2:0]      funct3;
    logic [6:0]      imm_MSB;
    logic [4:0]      imm_LSB;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] target_pc;
    logic            redirect;
    logic            misalign;
    logic            illegal;

    modport master (
        output in_valid, pc, funct3, imm_MSB, imm_LSB, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, taken, target_pc, redirect, misalign, illegal
    );

    modport slave (
        input  in_valid, pc, funct3, imm_MSB, imm_LSB, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, taken, target_pc, redirect, misalign, illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: rebuilds the B-type immediate, evaluates the condition,
// registers the result behind a valid/ready handshake and kills wrong-path beats on redirect.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int unsigned CNT_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CNT_W-1:0] r_kill_cnt;
    logic [CNT_W-1:0] w_kill_cnt_nxt;

    logic            r_out_valid;
    logic            r_taken;
    logic [XLEN-1:0] r_target;
    logic            r_redirect;
    logic            r_misalign;
    logic            r_illegal;

    logic [12:0]     w_imm13;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;
    logic            w_illegal;
    logic            w_taken;
    logic            w_redirect;
    logic            w_flush;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_discard;

    assign w_imm13  = {bus.imm_MSB[6], bus.imm_LSB[0], bus.imm_MSB[5:0], bus.imm_LSB[4:1], 1'b0};
    assign w_imm    = {{(XLEN - 13){w_imm13[12]}}, w_imm13};
    assign w_target = bus.pc + w_imm;

    assign w_eq  = (bus.rs1_data == bus.rs2_data);
    assign w_lt  = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
    assign w_ltu = (bus.rs1_data < bus.rs2_data);

    always_comb begin
        w_cond    = 1'b0;
        w_illegal = 1'b0;
        case (bus.funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = !w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = !w_ltu;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_taken    = w_cond & !w_illegal;
    assign w_redirect = w_taken & !w_target[1];

    // While flushing every beat is swallowed, so the stalled result never blocks the kill.
    assign w_flush    = (r_state == StFlush);
    assign w_in_ready = w_flush | !r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready & !w_flush;
    assign w_discard  = bus.in_valid & w_flush;

    always_comb begin
        w_state_nxt    = r_state;
        w_kill_cnt_nxt = r_kill_cnt;
        case (r_state)
            StRun: begin
                if (w_accept && w_redirect && (FLUSH_DEPTH != 0)) begin
                    w_state_nxt    = StFlush;
                    w_kill_cnt_nxt = CNT_W'(FLUSH_DEPTH);
                end
            end
            StFlush: begin
                if (w_discard) begin
                    w_kill_cnt_nxt = r_kill_cnt - 1'b1;
                    if (r_kill_cnt == CNT_W'(1)) begin
                        w_state_nxt = StRun;
                    end
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_kill_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
            r_redirect  <= 1'b0;
            r_misalign  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_kill_cnt <= w_kill_cnt_nxt;
            r_redirect <= w_accept & w_redirect;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_taken     <= w_taken;
                r_target    <= w_target;
                r_misalign  <= w_taken & w_target[1];
                r_illegal   <= w_illegal;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.taken     = r_taken;
    assign bus.target_pc = r_target;
    assign bus.redirect  = r_redirect;
    assign bus.misalign  = r_misalign;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(
        .XLEN(32),
        .FLUSH_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] pc, input logic [2:0] f3, input logic [6:0] msb,
                        input logic [4:0] lsb, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.pc       = pc;
        bus.funct3   = f3;
        bus.imm_MSB  = msb;
        bus.imm_LSB  = lsb;
        bus.rs1_data = a;
        bus.rs2_data = b;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.pc = '0; bus.funct3 = '0; bus.imm_MSB = '0; bus.imm_LSB = '0;
        bus.rs1_data = '0; bus.rs2_data = '0;
        do_reset();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken got %0b want 0", bus.taken); end
        n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect got %0b want 0", bus.redirect); end
        n_cmp++; if (bus.target_pc !== 32'h0) begin n_fail++; $display("FAIL rst_target got %h want 0", bus.target_pc); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_bgeu_target();
        do_reset();
        beat(32'h1000, 3'b111, 7'b0000111, 5'b01101, 32'd5, 32'd3);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_out_valid got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.taken !== 1'b1) begin n_fail++; $display("FAIL t1_taken got %0b want 1", bus.taken); end
        n_cmp++; if (bus.target_pc !== 32'h18EC) begin n_fail++; $display("FAIL t1_target got %h want 000018ec", bus.target_pc); end
        n_cmp++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL t1_redirect got %0b want 1", bus.redirect); end
        step();
        n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL t1_redirect_pulse got %0b want 0", bus.redirect); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drained got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_signed_unsigned();
        do_reset();
        beat(32'h2000, 3'b100, 7'h0, 5'h0, 32'hFFFFFFFF, 32'd1);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.taken !== 1'b1) begin n_fail++; $display("FAIL blt_taken got %0b want 1", bus.taken); end
        n_cmp++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL blt_redirect got %0b want 1", bus.redirect); end
        do_reset();
        beat(32'h2000, 3'b110, 7'h0, 5'h0, 32'hFFFFFFFF, 32'd1);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bltu_valid got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL bltu_taken got %0b want 0", bus.taken); end
        n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL bltu_redirect got %0b want 0", bus.redirect); end
    endtask

    task automatic test_neg_imm();
        do_reset();
        beat(32'h100, 3'b000, 7'b1111111, 5'b11101, 32'd9, 32'd9);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.target_pc !== 32'hFC) begin n_fail++; $display("FAIL neg_target got %h want 000000fc", bus.target_pc); end
        n_cmp++; if (bus.taken !== 1'b1) begin n_fail++; $display("FAIL neg_taken got %0b want 1", bus.taken); end
    endtask

    task automatic test_flush();
        do_reset();
        beat(32'h1000, 3'b111, 7'b0000111, 5'b01101, 32'd5, 32'd3);
        step();
        n_cmp++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL fl_redirect got %0b want 1", bus.redirect); end
        beat(32'h3000, 3'b000, 7'h0, 5'h0, 32'd1, 32'd2);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready got %0b want 1", bus.in_ready); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_kill1 got %0b want 0", bus.out_valid); end
        beat(32'h3800, 3'b000, 7'h0, 5'h0, 32'd1, 32'd2);
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_kill2 got %0b want 0", bus.out_valid); end
        beat(32'h4000, 3'b000, 7'h0, 5'b00100, 32'd1, 32'd2);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_third_valid got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.target_pc !== 32'h4004) begin n_fail++; $display("FAIL fl_third_target got %h want 00004004", bus.target_pc); end
        n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL fl_third_redirect got %0b want 0", bus.redirect); end
    endtask

    task automatic test_stall_and_reset();
        do_reset();
        bus.out_ready = 1'b0;
        beat(32'h100, 3'b000, 7'b1111111, 5'b11101, 32'd9, 32'd9);
        step();
        n_cmp++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL st_redirect got %0b want 1", bus.redirect); end
        beat(32'h5000, 3'b000, 7'h0, 5'h0, 32'd1, 32'd2);
        step();
        step();
        n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL st_redirect_once got %0b want 0", bus.redirect); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL st_in_ready[%0d] got %0b want 0", i, bus.in_ready); end
            n_cmp++; if (bus.target_pc !== 32'hFC || bus.taken !== 1'b1 || bus.out_valid !== 1'b1 || bus.redirect !== 1'b0) begin
                n_fail++;
                $display("FAIL st_hold[%0d] got tgt=%h tk=%0b v=%0b rd=%0b want tgt=000000fc tk=1 v=1 rd=0",
                         i, bus.target_pc, bus.taken, bus.out_valid, bus.redirect);
            end
            step();
        end
        bus.out_ready = 1'b1;
        beat(32'h1000, 3'b111, 7'b0000111, 5'b01101, 32'd5, 32'd3);
        step();
        n_cmp++; if (bus.target_pc !== 32'h18EC) begin n_fail++; $display("FAIL st_replace got %h want 000018ec", bus.target_pc); end
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if ({bus.out_valid, bus.taken, bus.redirect, bus.misalign, bus.illegal} !== 5'b0) begin
            n_fail++;
            $display("FAIL rf_flags got %b want 00000", {bus.out_valid, bus.taken, bus.redirect, bus.misalign, bus.illegal});
        end
        n_cmp++; if (bus.target_pc !== 32'h0) begin n_fail++; $display("FAIL rf_target got %h want 0", bus.target_pc); end
        beat(32'h6000, 3'b000, 7'h0, 5'h0, 32'd1, 32'd2);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.target_pc !== 32'h6000) begin
            n_fail++;
            $display("FAIL rf_run got v=%0b tgt=%h want v=1 tgt=00006000", bus.out_valid, bus.target_pc);
        end
    endtask

    task automatic test_illegal_misalign();
        do_reset();
        beat(32'h0, 3'b010, 7'h0, 5'h0, 32'd4, 32'd4);
        step();
        n_cmp++; if (bus.illegal !== 1'b1 || bus.taken !== 1'b0 || bus.redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_010 got il=%0b tk=%0b rd=%0b want il=1 tk=0 rd=0", bus.illegal, bus.taken, bus.redirect);
        end
        beat(32'h0, 3'b011, 7'h0, 5'h0, 32'd4, 32'd4);
        step();
        n_cmp++; if (bus.illegal !== 1'b1 || bus.taken !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_011 got il=%0b tk=%0b want il=1 tk=0", bus.illegal, bus.taken);
        end
        beat(32'h0, 3'b000, 7'h0, 5'b00011, 32'd7, 32'd7);
        step();
        n_cmp++; if (bus.target_pc !== 32'h802) begin n_fail++; $display("FAIL mis_target got %h want 00000802", bus.target_pc); end
        n_cmp++; if (bus.misalign !== 1'b1 || bus.redirect !== 1'b0 || bus.taken !== 1'b1 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_flags got ma=%0b rd=%0b tk=%0b il=%0b want ma=1 rd=0 tk=1 il=0",
                     bus.misalign, bus.redirect, bus.taken, bus.illegal);
        end
        beat(32'h700, 3'b000, 7'h0, 5'h0, 32'd1, 32'd2);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.target_pc !== 32'h700 || bus.misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_noflush got v=%0b tgt=%h ma=%0b want v=1 tgt=00000700 ma=0",
                     bus.out_valid, bus.target_pc, bus.misalign);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h100 * (i + 1);
            beat(exp_pc, 3'b001, 7'h0, 5'h0, 32'd3, 32'd3);
            step();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.target_pc !== exp_pc || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d] got v=%0b tgt=%h rdy=%0b want v=1 tgt=%h rdy=1",
                         i, bus.out_valid, bus.target_pc, bus.in_ready, exp_pc);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_bgeu_target();
        test_signed_unsigned();
        test_neg_imm();
        test_flush();
        test_stall_and_reset();
        test_illegal_misalign();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
